// File: rtl/axi_slave_mem.sv
// +--------------------------------------------------------------------------+
// | Module   : axi_slave_mem                                                 |
// | Brief    : AXI4 slave with 128-bit byte-strobed memory, independent      |
// |            write and read channels. Optional AXI_SLAVE_MEM_STALL_EN      |
// |            adds LFSR-driven backpressure on w_ready and r_valid launch.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_slave_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         slaveAxi_aw_valid,
  output logic         slaveAxi_aw_ready,
  input  logic [31:0]  slaveAxi_aw_payload_addr,
  input  logic [7:0]   slaveAxi_aw_payload_len,
  input  logic [1:0]   slaveAxi_aw_payload_burst,
  input  logic         slaveAxi_w_valid,
  output logic         slaveAxi_w_ready,
  input  logic [127:0] slaveAxi_w_payload_data,
  input  logic [15:0]  slaveAxi_w_payload_strb,
  input  logic         slaveAxi_w_payload_last,
  output logic         slaveAxi_b_valid,
  input  logic         slaveAxi_b_ready,
  output logic [1:0]   slaveAxi_b_payload_resp,
  input  logic         slaveAxi_ar_valid,
  output logic         slaveAxi_ar_ready,
  input  logic [31:0]  slaveAxi_ar_payload_addr,
  input  logic [7:0]   slaveAxi_ar_payload_len,
  input  logic [1:0]   slaveAxi_ar_payload_burst,
  output logic         slaveAxi_r_valid,
  input  logic         slaveAxi_r_ready,
  output logic [127:0] slaveAxi_r_payload_data,
  output logic [1:0]   slaveAxi_r_payload_resp,
  output logic         slaveAxi_r_payload_last
);

  localparam int unsigned c_IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0]  c_BURST_INCR  = 2'b01;
  localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
  localparam logic [31:0] c_WORD_BYTES  = 32'd16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  logic [127:0] r_mem [MEM_WORDS];

  function automatic logic [31:0] align(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

  // Unsupported burst types and addresses outside the window are both beat errors.
  function automatic logic beat_bad(input logic [31:0] addr, input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return burst[1] || (addr < BASE_ADDR) || ({4'h0, off[31:4]} >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [c_IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE_ADDR) >> 4;
    return off[c_IDX_W-1:0];
  endfunction

  logic w_stall;

`ifdef AXI_SLAVE_MEM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // ---------------------------------------------------------------- write
  w_state_t    r_wstate, w_wstate_nxt;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wbeat;
  logic [1:0]  r_wburst;
  logic        r_wdrain;
  logic        r_werr;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wbeat_bad;
  logic        w_wlast_beat;
  logic        w_wmismatch;
  logic        w_mem_we;

  assign w_aw_hs      = slaveAxi_aw_valid && (r_wstate == W_IDLE);
  assign w_w_hs       = slaveAxi_w_valid && (r_wstate == W_DATA) && !w_stall;
  assign w_wbeat_bad  = beat_bad(r_waddr, r_wburst);
  assign w_wlast_beat = (r_wbeat == r_wlen);
  assign w_wmismatch  = !r_wdrain && (slaveAxi_w_payload_last != w_wlast_beat);
  assign w_mem_we     = w_w_hs && !r_wdrain && !w_wbeat_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt            = r_wstate;
    slaveAxi_aw_ready       = 1'b0;
    slaveAxi_w_ready        = 1'b0;
    slaveAxi_b_valid        = 1'b0;
    slaveAxi_b_payload_resp = c_RESP_OKAY;
    case (r_wstate)
      W_IDLE: begin
        slaveAxi_aw_ready = !reset;
        if (w_aw_hs) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_DATA: begin
        slaveAxi_w_ready = !w_stall;
        if (w_w_hs && slaveAxi_w_payload_last) begin
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        slaveAxi_b_valid        = 1'b1;
        slaveAxi_b_payload_resp = r_werr ? c_RESP_SLVERR : c_RESP_OKAY;
        if (slaveAxi_b_ready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Once beat len passes without w_last, further beats are drained unwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wburst <= '0;
      r_wdrain <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_waddr  <= align(slaveAxi_aw_payload_addr);
      r_wlen   <= slaveAxi_aw_payload_len;
      r_wbeat  <= '0;
      r_wburst <= slaveAxi_aw_payload_burst;
      r_wdrain <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_w_hs && !r_wdrain) begin
      if (w_wbeat_bad || w_wmismatch) begin
        r_werr <= 1'b1;
      end
      if (!slaveAxi_w_payload_last) begin
        if (w_wlast_beat) begin
          r_wdrain <= 1'b1;
        end else begin
          r_wbeat <= r_wbeat + 8'd1;
          if (r_wburst == c_BURST_INCR) begin
            r_waddr <= r_waddr + c_WORD_BYTES;
          end
        end
      end
    end
  end

  // Storage is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 16; i++) begin
        if (slaveAxi_w_payload_strb[i]) begin
          r_mem[word_idx(r_waddr)][8*i +: 8] <= slaveAxi_w_payload_data[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t     r_rstate, w_rstate_nxt;
  logic [31:0]  r_raddr;
  logic [7:0]   r_rlen;
  logic [7:0]   r_rbeat;
  logic [1:0]   r_rburst;
  logic [127:0] r_rd_data;
  logic [1:0]   r_rd_resp;
  logic         r_rd_valid;
  logic         r_rd_last;
  logic         w_ar_hs;
  logic         w_r_hs;
  logic [31:0]  w_raddr_nxt;
  logic [31:0]  w_rsrc_addr;
  logic [1:0]   w_rsrc_burst;
  logic         w_rsrc_bad;
  logic [127:0] w_rsrc_data;

  assign w_ar_hs      = slaveAxi_ar_valid && (r_rstate == R_IDLE);
  assign w_r_hs       = r_rd_valid && slaveAxi_r_ready;
  assign w_raddr_nxt  = (r_rburst == c_BURST_INCR) ? r_raddr + c_WORD_BYTES : r_raddr;
  assign w_rsrc_addr  = w_ar_hs ? align(slaveAxi_ar_payload_addr) : w_raddr_nxt;
  assign w_rsrc_burst = w_ar_hs ? slaveAxi_ar_payload_burst : r_rburst;
  assign w_rsrc_bad   = beat_bad(w_rsrc_addr, w_rsrc_burst);
  assign w_rsrc_data  = w_rsrc_bad ? '0 : r_mem[word_idx(w_rsrc_addr)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt      = r_rstate;
    slaveAxi_ar_ready = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        slaveAxi_ar_ready = !reset;
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (w_r_hs && r_rd_last) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The beat is fetched into the output register on the handshake that
  // precedes it, so a same-cycle write to that word is not yet visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_raddr    <= '0;
      r_rlen     <= '0;
      r_rbeat    <= '0;
      r_rburst   <= '0;
      r_rd_data  <= '0;
      r_rd_resp  <= c_RESP_OKAY;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (w_ar_hs) begin
      r_raddr    <= w_rsrc_addr;
      r_rlen     <= slaveAxi_ar_payload_len;
      r_rbeat    <= '0;
      r_rburst   <= slaveAxi_ar_payload_burst;
      r_rd_data  <= w_rsrc_data;
      r_rd_resp  <= w_rsrc_bad ? c_RESP_SLVERR : c_RESP_OKAY;
      r_rd_last  <= (slaveAxi_ar_payload_len == 8'd0);
      r_rd_valid <= !w_stall;
    end else if (r_rstate == R_DATA) begin
      if (w_r_hs) begin
        if (r_rd_last) begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          r_rd_resp  <= c_RESP_OKAY;
        end else begin
          r_raddr    <= w_raddr_nxt;
          r_rbeat    <= r_rbeat + 8'd1;
          r_rd_data  <= w_rsrc_data;
          r_rd_resp  <= w_rsrc_bad ? c_RESP_SLVERR : c_RESP_OKAY;
          r_rd_last  <= ((r_rbeat + 8'd1) == r_rlen);
          r_rd_valid <= !w_stall;
        end
      end else if (!r_rd_valid) begin
        r_rd_valid <= !w_stall;
      end
    end
  end

  assign slaveAxi_r_valid        = r_rd_valid;
  assign slaveAxi_r_payload_data = r_rd_data;
  assign slaveAxi_r_payload_resp = r_rd_resp;
  assign slaveAxi_r_payload_last = r_rd_last;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_slave_mem                                              |
// | Brief    : Randomized self-checking bench for axi_slave_mem with a       |
// |            word-array reference model.                                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi_slave_mem;

  localparam int unsigned MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [1:0]   aw_burst;
  logic         w_valid, w_ready;
  logic [127:0] w_data;
  logic [15:0]  w_strb;
  logic         w_last;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic         ar_valid, ar_ready;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [1:0]   ar_burst;
  logic         r_valid, r_ready;
  logic [127:0] r_data;
  logic [1:0]   r_resp;
  logic         r_last;

  always #5 clk = ~clk;

  axi_slave_mem #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .slaveAxi_aw_valid         (aw_valid),
    .slaveAxi_aw_ready         (aw_ready),
    .slaveAxi_aw_payload_addr  (aw_addr),
    .slaveAxi_aw_payload_len   (aw_len),
    .slaveAxi_aw_payload_burst (aw_burst),
    .slaveAxi_w_valid          (w_valid),
    .slaveAxi_w_ready          (w_ready),
    .slaveAxi_w_payload_data   (w_data),
    .slaveAxi_w_payload_strb   (w_strb),
    .slaveAxi_w_payload_last   (w_last),
    .slaveAxi_b_valid          (b_valid),
    .slaveAxi_b_ready          (b_ready),
    .slaveAxi_b_payload_resp   (b_resp),
    .slaveAxi_ar_valid         (ar_valid),
    .slaveAxi_ar_ready         (ar_ready),
    .slaveAxi_ar_payload_addr  (ar_addr),
    .slaveAxi_ar_payload_len   (ar_len),
    .slaveAxi_ar_payload_burst (ar_burst),
    .slaveAxi_r_valid          (r_valid),
    .slaveAxi_r_ready          (r_ready),
    .slaveAxi_r_payload_data   (r_data),
    .slaveAxi_r_payload_resp   (r_resp),
    .slaveAxi_r_payload_last   (r_last)
  );

  int checks   = 0;
  int failures = 0;

  logic [127:0] model_mem [MW];
  logic [127:0] wd[$];
  logic [15:0]  ws[$];
  logic [127:0] rd_q[$], ed_q[$];
  logic [1:0]   rr_q[$], er_q[$];
  logic         rl_q[$], el_q[$];

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    logic [31:0] al;
    al = {a[31:4], 4'h0};
    if (burst == 2'b01) return al + 32'(i * 16);
    return al;
  endfunction

  function automatic bit beat_ok(input logic [31:0] a, input logic [1:0] burst);
    return (burst < 2) && (a >= BASE) && (((a - BASE) / 16) < MW);
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input int nbeats, output logic [1:0] resp);
    bit err;
    logic [31:0] a;
    err = (nbeats != len + 1);
    for (int i = 0; i < nbeats && i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      if (!beat_ok(a, burst)) err = 1;
      else for (int b = 0; b < 16; b++)
        if (ws[i][b]) model_mem[(a - BASE) / 16][8*b +: 8] = wd[i][8*b +: 8];
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
    logic [31:0] a;
    ed_q.delete(); er_q.delete(); el_q.delete();
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      ed_q.push_back(beat_ok(a, burst) ? model_mem[(a - BASE) / 16] : 128'h0);
      er_q.push_back(beat_ok(a, burst) ? 2'b00 : 2'b10);
      el_q.push_back(i == len);
    end
  endtask

  // ------------------------------------------------------- bus drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int nbeats, input int bhold, output logic [1:0] resp,
                           output int blat, output bit stable, output bit ok);
    int t;
    ok = 1; stable = 1; resp = 2'bxx; blat = -1;
    aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_valid = 1;
    t = 0;
    while (!aw_ready && t < 50) begin tick(); t++; end
    if (!aw_ready) begin ok = 0; aw_valid = 0; return; end
    tick();
    aw_valid = 0;
    for (int i = 0; i < nbeats; i++) begin
      w_data = wd[i]; w_strb = ws[i]; w_last = (i == nbeats - 1);
      w_valid = ($urandom_range(0, 3) != 0);
      t = 0;
      while (!(w_valid && w_ready) && t < 50) begin tick(); w_valid = 1; t++; end
      if (t >= 50) ok = 0;
      tick();
    end
    w_valid = 0; w_last = 0;
    t = 0;
    while (!b_valid && t < 50) begin tick(); t++; end
    if (!b_valid) begin ok = 0; return; end
    blat = t;
    resp = b_resp;
    for (int k = 0; k < bhold; k++) begin
      tick();
      if (b_valid !== 1'b1 || b_resp !== resp) stable = 0;
    end
    b_ready = 1;
    tick();
    b_ready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          output bit first_valid, output bit stable, output bit ok);
    int t, n;
    logic [127:0] pd;
    logic [1:0] pr;
    logic pl, pv;
    ok = 1; stable = 1; first_valid = 0;
    rd_q.delete(); rr_q.delete(); rl_q.delete();
    ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_valid = 1;
    t = 0;
    while (!ar_ready && t < 50) begin tick(); t++; end
    if (!ar_ready) ok = 0;
    tick();
    ar_valid = 0;
    first_valid = r_valid;
    n = 0; t = 0;
    while (ok && n <= len && t < 1000) begin
      r_ready = ($urandom_range(0, 2) != 0);
      if (r_valid && r_ready) begin
        rd_q.push_back(r_data); rr_q.push_back(r_resp); rl_q.push_back(r_last); n++;
      end
      pd = r_data; pr = r_resp; pl = r_last; pv = r_valid && !r_ready;
      tick();
      t++;
      if (pv && (r_valid !== 1'b1 || r_data !== pd || r_resp !== pr || r_last !== pl)) stable = 0;
    end
    r_ready = 0;
    if (n <= len) ok = 0;
    while (rd_q.size() <= len) begin
      rd_q.push_back('x); rr_q.push_back('x); rl_q.push_back(1'bx);
    end
  endtask

  task automatic fill_random(input int n, input logic [15:0] strb);
    wd.delete(); ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back({$urandom, $urandom, $urandom, $urandom});
      ws.push_back(strb);
    end
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1;
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_burst = 0; r_ready = 0;
    repeat (3) tick();
    checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_ready: got %b expected 000", {aw_ready, w_ready, ar_ready});
    end
    checks++;
    if ({b_valid, b_resp, r_valid, r_resp, r_last} !== 7'b0) begin
      failures++; $display("FAIL reset_valid_resp: got %b expected 0000000", {b_valid, b_resp, r_valid, r_resp, r_last});
    end
    checks++;
    if (r_data !== 128'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 0", r_data);
    end
    reset = 0;
    tick();
    checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000) begin
      failures++; $display("FAIL post_reset_idle: got %b expected 11000", {aw_ready, ar_ready, w_ready, b_valid, r_valid});
    end
  endtask

  task automatic test_fill();
    logic [1:0] resp, exp;
    int blat; bit st, ok;
    fill_random(MW, 16'hFFFF);
    axi_write(BASE, MW - 1, 2'b01, MW, 0, resp, blat, st, ok);
    model_write(BASE, MW - 1, 2'b01, MW, exp);
    checks++;
    if (!ok || resp !== exp) begin
      failures++; $display("FAIL fill_bresp: got %b ok=%0d expected %b", resp, ok, exp);
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    int blat; bit st, ok, fv;
    wd.delete(); ws.delete();
    for (int i = 1; i <= 4; i++) begin wd.push_back(128'(i)); ws.push_back(16'hFFFF); end
    axi_write(32'h40, 3, 2'b01, 4, 0, resp, blat, st, ok);
    for (int i = 0; i < 4; i++) model_mem[4 + i] = 128'(i + 1);
    checks++;
    if (!ok || resp !== 2'b00 || blat !== 0) begin
      failures++; $display("FAIL incr_bresp: got resp=%b latency=%0d expected resp=00 latency=0", resp, blat);
    end
    axi_read(32'h40, 3, 2'b01, fv, st, ok);
    checks++;
    if (!ok || fv !== 1'b1 || st !== 1'b1) begin
      failures++; $display("FAIL incr_read_timing: got ok=%0d first_valid=%0d stable=%0d expected 1 1 1", ok, fv, st);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== 128'(i + 1) || rr_q[i] !== 2'b00 || rl_q[i] !== (i == 3)) begin
        failures++;
        $display("FAIL incr_read beat %0d: got data=%h resp=%b last=%b expected data=%h resp=00 last=%0d",
                 i, rd_q[i], rr_q[i], rl_q[i], 128'(i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, exp;
    logic [127:0] old;
    int blat; bit st, ok, fv;
    old = model_mem[0];
    wd.delete(); ws.delete();
    wd.push_back({128{1'b1}}); ws.push_back(16'h000F);
    axi_write(BASE, 0, 2'b01, 1, 0, resp, blat, st, ok);
    model_write(BASE, 0, 2'b01, 1, exp);
    checks++;
    if (!ok || resp !== exp) begin
      failures++; $display("FAIL strobe_bresp: got %b expected %b", resp, exp);
    end
    axi_read(BASE, 0, 2'b01, fv, st, ok);
    checks++;
    if (!ok || rd_q[0] !== {old[127:32], 32'hFFFF_FFFF}) begin
      failures++; $display("FAIL strobe_read: got %h expected %h", rd_q[0], {old[127:32], 32'hFFFF_FFFF});
    end
  endtask

  task automatic test_fixed();
    logic [1:0] resp, exp;
    int blat; bit st, ok, fv;
    wd.delete(); ws.delete();
    wd.push_back(128'hA); wd.push_back(128'hB); wd.push_back(128'hC);
    repeat (3) ws.push_back(16'hFFFF);
    axi_write(32'h80, 2, 2'b00, 3, 0, resp, blat, st, ok);
    model_write(32'h80, 2, 2'b00, 3, exp);
    checks++;
    if (!ok || resp !== 2'b00 || exp !== 2'b00) begin
      failures++; $display("FAIL fixed_bresp: got %b expected 00", resp);
    end
    axi_read(32'h80, 0, 2'b01, fv, st, ok);
    checks++;
    if (!ok || rd_q[0] !== 128'hC) begin
      failures++; $display("FAIL fixed_read: got %h expected c", rd_q[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, exp;
    logic [31:0] oob;
    int blat; bit st, ok, fv;
    oob = BASE + MW * 16;
    axi_read(oob, 1, 2'b01, fv, st, ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!ok || rd_q[i] !== 128'h0 || rr_q[i] !== 2'b10 || rl_q[i] !== (i == 1)) begin
        failures++; $display("FAIL oob_read beat %0d: got data=%h resp=%b last=%b expected data=0 resp=10 last=%0d",
                             i, rd_q[i], rr_q[i], rl_q[i], (i == 1));
      end
    end
    fill_random(2, 16'hFFFF);
    axi_write(oob, 1, 2'b01, 2, 0, resp, blat, st, ok);
    model_write(oob, 1, 2'b01, 2, exp);
    checks++;
    if (!ok || resp !== 2'b10) begin
      failures++; $display("FAIL oob_bresp: got %b expected 10", resp);
    end
    model_read(oob - 32, 1, 2'b01);
    axi_read(oob - 32, 1, 2'b01, fv, st, ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i]) begin
        failures++; $display("FAIL oob_unchanged beat %0d: got %h expected %h", i, rd_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_early_last();
    logic [1:0] resp, exp;
    int blat; bit st, ok, fv;
    fill_random(2, 16'hFFFF);
    axi_write(32'h200, 3, 2'b01, 2, 5, resp, blat, st, ok);
    model_write(32'h200, 3, 2'b01, 2, exp);
    checks++;
    if (!ok || resp !== 2'b10) begin
      failures++; $display("FAIL early_last_bresp: got %b expected 10", resp);
    end
    checks++;
    if (st !== 1'b1) begin
      failures++; $display("FAIL early_last_bstable: got stable=%0d expected 1", st);
    end
    model_read(32'h200, 3, 2'b01);
    axi_read(32'h200, 3, 2'b01, fv, st, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i] || rl_q[i] !== el_q[i]) begin
        failures++; $display("FAIL early_last_read beat %0d: got %h expected %h", i, rd_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_missing_last();
    logic [1:0] resp, exp;
    int blat; bit st, ok, fv;
    fill_random(4, 16'hFFFF);
    axi_write(32'h100, 1, 2'b01, 4, 0, resp, blat, st, ok);
    model_write(32'h100, 1, 2'b01, 4, exp);
    checks++;
    if (!ok || resp !== 2'b10) begin
      failures++; $display("FAIL missing_last_bresp: got %b expected 10", resp);
    end
    model_read(32'h100, 3, 2'b01);
    axi_read(32'h100, 3, 2'b01, fv, st, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i] || rl_q[i] !== el_q[i]) begin
        failures++; $display("FAIL missing_last_read beat %0d: got %h expected %h", i, rd_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp, exp;
    int blat; bit st, ok, fv;
    fill_random(2, 16'hFFFF);
    axi_write(32'hFFFF_FFF5, 1, 2'b01, 2, 0, resp, blat, st, ok);
    model_write(32'hFFFF_FFF5, 1, 2'b01, 2, exp);
    checks++;
    if (!ok || resp !== exp) begin
      failures++; $display("FAIL wrap_bresp: got %b expected %b", resp, exp);
    end
    model_read(32'hFFFF_FFF0, 1, 2'b01);
    axi_read(32'hFFFF_FFF0, 1, 2'b01, fv, st, ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i] || rl_q[i] !== el_q[i]) begin
        failures++; $display("FAIL wrap_read beat %0d: got data=%h resp=%b expected data=%h resp=%b",
                             i, rd_q[i], rr_q[i], ed_q[i], er_q[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [127:0] old, nw;
    old = model_mem[5];
    nw  = {$urandom, $urandom, $urandom, $urandom};
    aw_addr = 32'h50; aw_len = 0; aw_burst = 2'b01; aw_valid = 1;
    tick();
    aw_valid = 0;
    w_data = nw; w_strb = 16'hFFFF; w_last = 1; w_valid = 1;
    ar_addr = 32'h50; ar_len = 0; ar_burst = 2'b01; ar_valid = 1;
    checks++;
    if ({w_ready, ar_ready} !== 2'b11) begin
      failures++; $display("FAIL same_cycle_ready: got %b expected 11", {w_ready, ar_ready});
    end
    tick();
    w_valid = 0; w_last = 0; ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== old) begin
      failures++; $display("FAIL same_cycle_read: got valid=%b data=%h expected valid=1 data=%h", r_valid, r_data, old);
    end
    checks++;
    if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      failures++; $display("FAIL same_cycle_bresp: got valid=%b resp=%b expected 1 00", b_valid, b_resp);
    end
    r_ready = 1; b_ready = 1;
    tick();
    r_ready = 0; b_ready = 0;
    model_mem[5] = nw;
    ar_addr = 32'h50; ar_valid = 1;
    tick();
    ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== nw) begin
      failures++; $display("FAIL same_cycle_after: got %h expected %h", r_data, nw);
    end
    r_ready = 1;
    tick();
    r_ready = 0;
  endtask

  task automatic test_reset_mid_read();
    bit st, ok, fv;
    ar_addr = 32'h300; ar_len = 7; ar_burst = 2'b01; ar_valid = 1;
    tick();
    ar_valid = 0; r_ready = 1;
    repeat (2) tick();
    r_ready = 0;
    #2 reset = 1;
    #1;
    checks++;
    if ({r_valid, r_last, ar_ready, aw_ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_mid_read: got %b expected 0000", {r_valid, r_last, ar_ready, aw_ready});
    end
    repeat (2) tick();
    reset = 0;
    tick();
    model_read(32'h300, 3, 2'b01);
    axi_read(32'h300, 3, 2'b01, fv, st, ok);
    checks++;
    if (!ok || fv !== 1'b1) begin
      failures++; $display("FAIL reset_mid_read_restart: got ok=%0d first_valid=%0d expected 1 1", ok, fv);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i] || rl_q[i] !== el_q[i]) begin
        failures++; $display("FAIL reset_mid_read beat %0d: got %h expected %h", i, rd_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp, burst;
    logic [31:0] addr;
    int len, sel, blat; bit st, ok, fv;
    for (int it = 0; it < 24; it++) begin
      addr = BASE + 32'($urandom_range(0, MW + 4) * 16 + $urandom_range(0, 15));
      len  = $urandom_range(0, 7);
      sel  = $urandom_range(0, 9);
      burst = (sel == 0) ? 2'($urandom_range(2, 3)) : (sel < 4) ? 2'b00 : 2'b01;
      fill_random(len + 1, 16'hFFFF);
      for (int i = 0; i <= len; i++) ws[i] = 16'($urandom);
      axi_write(addr, len, burst, len + 1, $urandom_range(0, 2), resp, blat, st, ok);
      model_write(addr, len, burst, len + 1, exp);
      checks++;
      if (!ok || resp !== exp || st !== 1'b1) begin
        failures++; $display("FAIL random_bresp it %0d: got %b ok=%0d stable=%0d expected %b", it, resp, ok, st, exp);
      end
      model_read(addr, len, burst);
      axi_read(addr, len, burst, fv, st, ok);
      checks++;
      if (!ok || st !== 1'b1) begin
        failures++; $display("FAIL random_rstable it %0d: got ok=%0d stable=%0d expected 1 1", it, ok, st);
      end
      for (int i = 0; i <= len; i++) begin
        checks++;
        if (rd_q[i] !== ed_q[i] || rr_q[i] !== er_q[i] || rl_q[i] !== el_q[i]) begin
          failures++;
          $display("FAIL random_read it %0d beat %0d: got data=%h resp=%b last=%b expected data=%h resp=%b last=%b",
                   it, i, rd_q[i], rr_q[i], rl_q[i], ed_q[i], er_q[i], el_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr();
    test_strobe();
    test_fixed();
    test_out_of_range();
    test_early_last();
    test_missing_last();
    test_wrap();
    test_same_cycle();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 128-bit storage words, power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0, 16-byte aligned.
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- slaveAxi_aw_valid/ready  in/out  1/1  write-address handshake.
- slaveAxi_aw_payload_addr  in  32  byte address; bits [3:0] ignored.
- slaveAxi_aw_payload_len  in  8  beats minus one.
- slaveAxi_aw_payload_burst  in  2  00 FIXED, 01 INCR, other unsupported.
- slaveAxi_w_valid/ready  in/out  1/1  write-data handshake.
- slaveAxi_w_payload_data  in  128  write beat.
- slaveAxi_w_payload_strb  in  16  byte enables, bit i covers data[8i+7:8i].
- slaveAxi_w_payload_last  in  1  final write beat.
- slaveAxi_b_valid/ready  out/in  1/1  write-response handshake.
- slaveAxi_b_payload_resp  out  2  00 OKAY, 10 SLVERR.
- slaveAxi_ar_valid/ready  in/out  1/1  read-address handshake.
- slaveAxi_ar_payload_addr  in  32  byte address; bits [3:0] ignored.
- slaveAxi_ar_payload_len  in  8  beats minus one.
- slaveAxi_ar_payload_burst  in  2  same encoding as aw.
- slaveAxi_r_valid/ready  out/in  1/1  read-data handshake.
- slaveAxi_r_payload_data  out  128  read beat.
- slaveAxi_r_payload_resp  out  2  00 OKAY, 10 SLVERR.
- slaveAxi_r_payload_last  out  1  final read beat.

Function
REQ-004 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; the two SHALL run independently.
- W_IDLE: aw_ready=1; on aw handshake latch addr, len and burst, clear the beat counter, go to W_DATA next cycle.
- W_DATA: w_ready=1; on each w handshake write the strobed bytes of the current word, then advance: INCR adds 1 word, FIXED holds.
- Beat index len with w_last=1: go to W_RESP.
- w_last mismatch (early, or missing at beat len): record SLVERR; on early last go to W_RESP; on missing last stay in W_DATA discarding beats until w_last.
- W_RESP: b_valid=1 the cycle after the last w handshake; hold b_valid and resp stable until b_ready; then return to W_IDLE.
- R_IDLE: ar_ready=1; on handshake latch the request and enter R_DATA; first r_valid in the next cycle.
- R_DATA: r_valid=1; one beat per cycle while r_ready=1; data, resp and last stable while r_valid=1 and r_ready=0; r_last=1 only on beat len; return to R_IDLE after that handshake.
REQ-005 Word index SHALL be (addr-BASE_ADDR)>>4; a beat whose index is >= MEM_WORDS or below BASE_ADDR SHALL return SLVERR, SHALL suppress the write, and SHALL read as all-zero data.
REQ-006 Unsupported burst (10, 11) SHALL be SLVERR for the whole burst; no memory writes; read data zero.
REQ-007 Write response SHALL be SLVERR if any beat erred, otherwise OKAY; r resp SHALL be per beat.
REQ-008 A read and a write to the same word in the same cycle SHALL return the pre-write data.
REQ-009 The 32-bit address increment SHALL wrap modulo 2^32; a wrapped address falls under REQ-005.

Reset
REQ-010 While reset=1, both FSMs SHALL be idle and all valid, ready, last and resp outputs SHALL be 0; r_data SHALL be 0.
REQ-011 Reset mid-burst SHALL abandon the transaction with no response; memory contents SHALL NOT be cleared, and beats already written SHALL remain.

Configuration
REQ-012 With AXI_SLAVE_MEM_STALL_EN defined, a 16-bit LFSR (seed 16'hACE1, reset-loaded) SHALL gate w_ready and the r_valid launch low when its two LSBs are 00; an r_valid already asserted SHALL not drop. Without the macro, no stall logic SHALL exist and throughput SHALL be one beat per cycle.

Verification
REQ-013 Benches SHALL cover:
- INCR write addr 0x40, len 3, strb 0xFFFF, data 0x1..0x4 -> b_resp 00; INCR read addr 0x40, len 3 -> 0x1..0x4, r_last on 4th beat only.
- Write strb 0x000F of 0xFFFF..FF over word 0 -> read word 0 shows only bytes 0-3 changed.
- FIXED write len 2 with data A, B, C to 0x80 -> read 0x80 returns C.
- Read addr BASE_ADDR+MEM_WORDS*16, len 1 -> two beats, resp 10, data 0; write to the same address -> b_resp 10, memory unchanged.
- w_last asserted on beat 1 of len 3 -> b_resp 10; b_ready held low 5 cycles -> b_valid and resp stable; reset asserted mid read burst -> r_valid low, next ar accepted cleanly.
